// File: rtl/controle_preparo_pkg.sv
// controle_preparo_pkg
//   Shared definitions for the brew sequencer: FSM state encoding,
//   sensor-check status values and front-panel display codes.
package controle_preparo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_HEAT  = 3'd2,
    ST_PUMP  = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  // Sensor checker status
  localparam logic [1:0] ANALISE = 2'b00;
  localparam logic [1:0] ERRO    = 2'b01;
  localparam logic [1:0] OK      = 2'b10;
  localparam logic [1:0] FALHA   = 2'b11;

  // Display codes
  localparam logic [3:0] DISP_IDLE    = 4'b0000;
  localparam logic [3:0] DISP_HEAT    = 4'b0001;
  localparam logic [3:0] DISP_PUMP    = 4'b0010;
  localparam logic [3:0] DISP_DONE    = 4'b0011;
  localparam logic [3:0] DISP_ANALISE = 4'b1000;
  localparam logic [3:0] DISP_FAULT   = 4'b1111;

  // While waiting for a verdict the display shows the error code if one
  // is reported, otherwise the "analysing" pattern.
  function automatic logic [3:0] disp_check(input logic [1:0] sts, input logic [3:0] cod);
    return (sts == ERRO) ? cod : DISP_ANALISE;
  endfunction

endpackage

// File: rtl/controle_preparo_if.sv
// controle_preparo_if
//   Front-panel / sensor / actuator bundle of the brew sequencer.
//   master : drives start, saida_sensores, cod_erro (panel + sensor checker)
//   slave  : the sequencer; drives timer, heater, pump, busy, ready,
//            fault and display.
interface controle_preparo_if;
  logic       start;
  logic [1:0] saida_sensores;
  logic [3:0] cod_erro;
  logic       timer;
  logic       heater;
  logic       pump;
  logic       busy;
  logic       ready;
  logic       fault;
  logic [3:0] display;

  modport master (
    output start, saida_sensores, cod_erro,
    input  timer, heater, pump, busy, ready, fault, display
  );

  modport slave (
    input  start, saida_sensores, cod_erro,
    output timer, heater, pump, busy, ready, fault, display
  );
endinterface

// File: rtl/controle_preparo_contador_tempo.sv
// controle_preparo_contador_tempo
//   Saturating CW-bit up-counter shared by the timed states.
//   i_clk, i_rst : clock, async active-high reset
//   i_clr        : synchronous clear (wins over enable)
//   i_en         : count enable
//   i_term       : terminal value for the compare
//   o_tc         : high while the count equals i_term
module controle_preparo_contador_tempo #(
  parameter int unsigned CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [CW-1:0] i_term,
  output logic          o_tc
);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {CW{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == i_term);

endmodule

// File: rtl/controle_preparo.sv
// controle_preparo
//   Brew sequencer: on a START press waits for the sensor verdict (with a
//   timeout that raises TIMER), then runs heat and pump phases and pulses
//   READY. A sensor fault latches FAULT until reset.
//   i_clk, i_rst : clock, async active-high reset
//   bus (slave)  : start, saida_sensores, cod_erro in;
//                  timer, heater, pump, busy, ready, fault, display out
//   Parameters   : T_TIMEOUT (>=2), T_HEAT (>=1), T_PUMP (>=1) in cycles;
//                  CW counter width, 2^CW must exceed all three.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | waiting for a START rising edge
//   ST_CHECK | waiting for the sensor verdict, timeout running
//   ST_HEAT  | heater on for T_HEAT cycles
//   ST_PUMP  | pump on for T_PUMP cycles
//   ST_DONE  | one-cycle READY pulse
//   ST_FAULT | latched fault, left only by reset
module controle_preparo
  import controle_preparo_pkg::*;
#(
  parameter int unsigned T_TIMEOUT = 16,
  parameter int unsigned T_HEAT    = 32,
  parameter int unsigned T_PUMP    = 24,
  parameter int unsigned CW        = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  controle_preparo_if.slave   bus
);

  localparam logic [CW-1:0] L_TERM_CHECK = CW'(T_TIMEOUT - 1);
  localparam logic [CW-1:0] L_TERM_HEAT  = CW'(T_HEAT - 1);
  localparam logic [CW-1:0] L_TERM_PUMP  = CW'(T_PUMP - 1);

  state_t      r_state;
  state_t      w_state_next;

  logic        r_start_q;
  logic        r_armed;
  logic        w_start_edge;

  logic        r_timer, r_heater, r_pump, r_busy, r_ready, r_fault;
  logic [3:0]  r_display;
  logic        w_timer_next, w_heater_next, w_pump_next, w_busy_next;
  logic        w_ready_next, w_fault_next;
  logic [3:0]  w_display_next;

  logic        w_cnt_clr;
  logic        w_cnt_en;
  logic        w_tc;
  logic [CW-1:0] w_term;

  // r_armed only sets after START has been seen low out of reset, so a
  // button held through reset release cannot count as a press.
  assign w_start_edge = bus.start & ~r_start_q & r_armed;

  // Counter restarts on every state change; it only runs in timed states.
  assign w_cnt_clr = (w_state_next != r_state);
  assign w_cnt_en  = (r_state == ST_CHECK) || (r_state == ST_HEAT) || (r_state == ST_PUMP);

  always_comb begin
    w_term = '0;
    case (r_state)
      ST_CHECK: w_term = L_TERM_CHECK;
      ST_HEAT:  w_term = L_TERM_HEAT;
      ST_PUMP:  w_term = L_TERM_PUMP;
      default:  w_term = '0;
    endcase
  end

  controle_preparo_contador_tempo #(.CW(CW)) u_contador_tempo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .i_term (w_term),
    .o_tc   (w_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer;
    w_display_next = r_display;

    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        // A clean verdict beats a timeout landing on the same cycle.
        if (bus.saida_sensores == OK) begin
          w_state_next = ST_HEAT;
        end else if (bus.saida_sensores == FALHA) begin
          w_state_next = ST_FAULT;
        end else if (w_tc) begin
          w_state_next = ST_FAULT;
          w_timer_next = 1'b1;
        end
      end
      ST_HEAT: begin
        if (bus.saida_sensores == FALHA) w_state_next = ST_FAULT;
        else if (w_tc)                   w_state_next = ST_PUMP;
      end
      ST_PUMP: begin
        if (bus.saida_sensores == FALHA) w_state_next = ST_FAULT;
        else if (w_tc)                   w_state_next = ST_DONE;
      end
      ST_DONE:  w_state_next = ST_IDLE;
      ST_FAULT: w_state_next = ST_FAULT;
      default:  w_state_next = ST_IDLE;
    endcase

    // Outputs follow the state being entered so they move on the same edge.
    w_heater_next = (w_state_next == ST_HEAT);
    w_pump_next   = (w_state_next == ST_PUMP);
    w_ready_next  = (w_state_next == ST_DONE);
    w_fault_next  = (w_state_next == ST_FAULT);
    w_busy_next   = (w_state_next == ST_CHECK) || (w_state_next == ST_HEAT) ||
                    (w_state_next == ST_PUMP)  || (w_state_next == ST_DONE);

    case (w_state_next)
      ST_CHECK: w_display_next = disp_check(bus.saida_sensores, bus.cod_erro);
      ST_HEAT:  w_display_next = DISP_HEAT;
      ST_PUMP:  w_display_next = DISP_PUMP;
      ST_DONE:  w_display_next = DISP_DONE;
      ST_FAULT: w_display_next = DISP_FAULT;
      default:  w_display_next = r_display;  // IDLE keeps the last code
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_start_q <= 1'b0;
      r_armed   <= 1'b0;
      r_timer   <= 1'b0;
      r_heater  <= 1'b0;
      r_pump    <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
      r_display <= DISP_IDLE;
    end else begin
      r_start_q <= bus.start;
      r_armed   <= r_armed | ~bus.start;
      r_timer   <= w_timer_next;
      r_heater  <= w_heater_next;
      r_pump    <= w_pump_next;
      r_busy    <= w_busy_next;
      r_ready   <= w_ready_next;
      r_fault   <= w_fault_next;
      r_display <= w_display_next;
    end
  end

  assign bus.timer   = r_timer;
  assign bus.heater  = r_heater;
  assign bus.pump    = r_pump;
  assign bus.busy    = r_busy;
  assign bus.ready   = r_ready;
  assign bus.fault   = r_fault;
  assign bus.display = r_display;

endmodule

// File: tb/tb_controle_preparo.sv
module tb_controle_preparo;

  localparam int T_TIMEOUT = 8;
  localparam int T_HEAT    = 4;
  localparam int T_PUMP    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  controle_preparo_if bus();

  controle_preparo #(
    .T_TIMEOUT (T_TIMEOUT),
    .T_HEAT    (T_HEAT),
    .T_PUMP    (T_PUMP),
    .CW        (8)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // {timer, heater, pump, busy, ready, fault, display}
  function automatic logic [9:0] pk(input logic t, input logic h, input logic p,
                                    input logic b, input logic r, input logic f,
                                    input logic [3:0] d);
    return {t, h, p, b, r, f, d};
  endfunction

  function automatic logic [9:0] obs();
    return {bus.timer, bus.heater, bus.pump, bus.busy, bus.ready, bus.fault, bus.display};
  endfunction

  // Expected outputs i cycles after HEAT was entered (no fault, no restart).
  function automatic logic [9:0] exp_brew(input int i);
    logic h, p, r, b;
    logic [3:0] d;
    h = (i < T_HEAT);
    p = (i >= T_HEAT) && (i < T_HEAT + T_PUMP);
    r = (i == T_HEAT + T_PUMP);
    b = (i <= T_HEAT + T_PUMP);
    if (i < T_HEAT)               d = 4'b0001;
    else if (i < T_HEAT + T_PUMP) d = 4'b0010;
    else                          d = 4'b0011;
    return pk(1'b0, h, p, b, r, 1'b0, d);
  endfunction

  function automatic logic [3:0] exp_check_disp(input logic [1:0] s, input logic [3:0] c);
    return (s == 2'b01) ? c : 4'b1000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.saida_sensores = 2'b00;
    bus.cod_erro = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
  endtask

  // Presses START, spends d cycles in CHECK with non-verdict statuses, then
  // presents OK. mode 0: random 00/01 and code; 1: 01 with fixed code;
  // 2: 01 with a new random code every cycle.
  task automatic run_to_heat(input int d, input int mode, input logic [3:0] code);
    logic [1:0] s;
    logic [3:0] c;
    bus.start = 1'b0;
    bus.saida_sensores = 2'b00;
    tick();
    bus.start = 1'b1;
    tick();
    n_checks++;
    if (obs() !== pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000)) begin
      n_errors++;
      $display("FAIL check_entry: got %b expected %b", obs(), pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000));
    end
    for (int j = 0; j < d; j++) begin
      s = (mode == 0) ? 2'($urandom_range(0, 1)) : 2'b01;
      c = (mode == 1) ? code : 4'($urandom);
      bus.saida_sensores = s;
      bus.cod_erro = c;
      tick();
      n_checks++;
      if (obs() !== pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, exp_check_disp(s, c))) begin
        n_errors++;
        $display("FAIL check_wait[%0d]: got %b expected %b", j, obs(),
                 pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, exp_check_disp(s, c)));
      end
    end
    bus.saida_sensores = 2'b10;
    tick();
    n_checks++;
    if (obs() !== exp_brew(0)) begin
      n_errors++;
      $display("FAIL heat_entry(d=%0d): got %b expected %b", d, obs(), exp_brew(0));
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.saida_sensores = 2'b00;
    bus.cod_erro = 4'b0000;
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs() !== 10'b0) begin
      n_errors++;
      $display("FAIL reset_state: got %b expected %b", obs(), 10'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.saida_sensores = 2'($urandom_range(0, 3));
      bus.cod_erro = 4'($urandom);
      tick();
      n_checks++;
      if (obs() !== 10'b0) begin
        n_errors++;
        $display("FAIL idle_ignores_status[%0d]: got %b expected %b", i, obs(), 10'b0);
      end
    end
  endtask

  task automatic test_clean_brew();
    int d;
    for (int it = 0; it < 5; it++) begin
      d = (it == 0) ? 0 : (it == 1) ? T_TIMEOUT - 1 : int'($urandom_range(0, T_TIMEOUT - 1));
      run_to_heat(d, 0, 4'b0000);
      // START stays high through DONE: IDLE must not restart.
      for (int i = 1; i < T_HEAT + T_PUMP + 4; i++) begin
        bus.saida_sensores = 2'($urandom_range(0, 2));
        tick();
        n_checks++;
        if (obs() !== exp_brew(i)) begin
          n_errors++;
          $display("FAIL clean_brew(d=%0d)[%0d]: got %b expected %b", d, i, obs(), exp_brew(i));
        end
      end
      bus.start = 1'b0;
      bus.saida_sensores = 2'b00;
      tick();
    end
  endtask

  task automatic test_recovered_error();
    for (int it = 0; it < 3; it++) begin
      if (it == 0) run_to_heat(5, 1, 4'b0110);
      else run_to_heat(int'($urandom_range(1, T_TIMEOUT - 1)), 2, 4'b0000);
      for (int i = 1; i < T_HEAT + T_PUMP + 2; i++) begin
        bus.saida_sensores = 2'($urandom_range(0, 2));
        tick();
        n_checks++;
        if (obs() !== exp_brew(i)) begin
          n_errors++;
          $display("FAIL recovered_brew[%0d]: got %b expected %b", i, obs(), exp_brew(i));
        end
      end
      bus.start = 1'b0;
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [1:0] s;
    logic [3:0] c;
    logic [9:0] e;
    for (int it = 0; it < 2; it++) begin
      do_reset();
      bus.start = 1'b1;
      tick();
      for (int j = 0; j < T_TIMEOUT; j++) begin
        s = (it == 0) ? 2'b01 : 2'($urandom_range(0, 1));
        c = (it == 0) ? 4'b0101 : 4'($urandom);
        bus.saida_sensores = s;
        bus.cod_erro = c;
        tick();
        if (j < T_TIMEOUT - 1) e = pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, exp_check_disp(s, c));
        else                   e = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111);
        n_checks++;
        if (obs() !== e) begin
          n_errors++;
          $display("FAIL timeout[%0d]: got %b expected %b", j, obs(), e);
        end
      end
      for (int k = 0; k < 6; k++) begin
        bus.saida_sensores = 2'($urandom_range(0, 3));
        bus.start = k[0];
        tick();
        n_checks++;
        if (obs() !== pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111)) begin
          n_errors++;
          $display("FAIL timeout_sticky[%0d]: got %b expected %b", k, obs(),
                   pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111));
        end
      end
      do_reset();
      n_checks++;
      if (obs() !== 10'b0) begin
        n_errors++;
        $display("FAIL timeout_cleared_by_reset: got %b expected %b", obs(), 10'b0);
      end
    end
  endtask

  task automatic test_sensor_fault_check();
    int k;
    for (int it = 0; it < 3; it++) begin
      k = (it == 0) ? T_TIMEOUT - 1 : int'($urandom_range(0, T_TIMEOUT - 2));
      do_reset();
      bus.start = 1'b1;
      tick();
      for (int j = 0; j < k; j++) begin
        bus.saida_sensores = 2'($urandom_range(0, 1));
        tick();
      end
      bus.saida_sensores = 2'b11;
      tick();
      n_checks++;
      if (obs() !== pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111)) begin
        n_errors++;
        $display("FAIL check_sensor_fault(k=%0d): got %b expected %b", k, obs(),
                 pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111));
      end
    end
  endtask

  task automatic test_mid_brew_fault();
    int f;
    for (int it = 0; it < 4; it++) begin
      f = (it == 0) ? T_HEAT + 1 : (it == 1) ? T_HEAT + T_PUMP - 1 : int'($urandom_range(0, T_HEAT + T_PUMP - 1));
      do_reset();
      run_to_heat(0, 0, 4'b0000);
      for (int i = 1; i <= f; i++) begin
        bus.saida_sensores = 2'($urandom_range(0, 2));
        tick();
        n_checks++;
        if (obs() !== exp_brew(i)) begin
          n_errors++;
          $display("FAIL pre_fault_brew[%0d]: got %b expected %b", i, obs(), exp_brew(i));
        end
      end
      bus.saida_sensores = 2'b11;
      tick();
      n_checks++;
      if (obs() !== pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111)) begin
        n_errors++;
        $display("FAIL mid_brew_fault(f=%0d): got %b expected %b", f, obs(),
                 pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111));
      end
      bus.saida_sensores = 2'b10;
      bus.start = 1'b0;
      tick();
      bus.start = 1'b1;
      tick();
      tick();
      n_checks++;
      if (obs() !== pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111)) begin
        n_errors++;
        $display("FAIL fault_ignores_start: got %b expected %b", obs(),
                 pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111));
      end
    end
  endtask

  task automatic test_reset_mid_heat();
    do_reset();
    run_to_heat(int'($urandom_range(0, 3)), 0, 4'b0000);
    bus.saida_sensores = 2'b00;
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 10'b0) begin
      n_errors++;
      $display("FAIL async_reset_mid_heat: got %b expected %b", obs(), 10'b0);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs() !== 10'b0) begin
        n_errors++;
        $display("FAIL start_held_after_reset[%0d]: got %b expected %b", i, obs(), 10'b0);
      end
    end
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    n_checks++;
    if (obs() !== pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000)) begin
      n_errors++;
      $display("FAIL fresh_edge_after_reset: got %b expected %b", obs(),
               pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.saida_sensores = 2'b00;
    bus.cod_erro = 4'b0000;
    test_reset();
    test_clean_brew();
    test_recovered_error();
    test_timeout();
    test_sensor_fault_check();
    test_mid_brew_fault();
    test_reset_mid_heat();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
